// File: rtl/game_pkg.sv
// Shared definitions for the inter-board game link: frame tags, player codes,
// decoder state encoding and the published remote-player record.
package game_pkg;

  localparam logic [2:0] UART_TAG_HDR  = 3'd0;
  localparam logic [2:0] UART_TAG_XLO  = 3'd1;
  localparam logic [2:0] UART_TAG_XHI  = 3'd2;
  localparam logic [2:0] UART_TAG_YHI  = 3'd3;
  localparam logic [2:0] UART_TAG_YLO  = 3'd4;
  localparam logic [2:0] UART_TAG_COLL = 3'd5;

  localparam logic [1:0] PLAYER_NONE = 2'b00;
  localparam logic [1:0] PLAYER_1    = 2'b01;
  localparam logic [1:0] PLAYER_2    = 2'b11;

  typedef enum logic {
    S_WAIT,
    S_PARSE
  } uart_dec_state_t;

  typedef struct packed {
    logic [1:0] player;
    logic [7:0] x;
    logic [7:0] y;
    logic       collision;
  } remote_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Bit 7 must be clear; the header and collision bytes also carry reserved zeros.
  function automatic logic byte_well_formed(input logic [7:0] b);
    logic ok;
    ok = ~b[7];
    case (b[2:0])
      UART_TAG_HDR:  ok = ok & (b[6:5] == 2'b00);
      UART_TAG_COLL: ok = ok & (b[6:4] == 3'b000);
      3'd6, 3'd7:    ok = 1'b0;
      default:       ok = ok;
    endcase
    return ok;
  endfunction

  // Codes 01 and 11 name a real player; 00 and 10 mean nobody is playing.
  function automatic logic player_active(input logic [1:0] p);
    return p[0];
  endfunction

endpackage

// File: rtl/uart_decoder.sv
// Pops bytes from the RX FIFO, reassembles 6-byte tagged position frames and
// publishes the remote player state atomically, with frame and link timeouts.
module uart_decoder
  import game_pkg::*;
#(
  parameter int FRAME_TIMEOUT = 100_000,
  parameter int LINK_TIMEOUT  = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic [1:0] remote_player,
  output logic [7:0] remote_x,
  output logic [7:0] remote_y,
  output logic       remote_collision,
  output logic       frame_valid,
  output logic       link_up,
  output logic [7:0] err_count
);

  localparam int FW = $clog2(FRAME_TIMEOUT + 1);
  localparam int LW = $clog2(LINK_TIMEOUT + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TIMEOUT - 1);
  localparam logic [LW-1:0] LINK_MAX   = LW'(LINK_TIMEOUT);

  uart_dec_state_t r_state;
  logic [7:0]      r_byte;
  logic [2:0]      r_exp;
  remote_state_t   r_shadow;
  remote_state_t   r_remote;
  logic            r_publish;
  logic            r_frameValid;
  logic [7:0]      r_errCount;
  logic [FW-1:0]   r_frameTimer;
  logic [LW-1:0]   r_linkTimer;
  logic            r_linkUp;

  logic [2:0] w_tag;
  logic       w_wellFormed;
  logic       w_tagMatch;
  logic       w_frameTimeout;

  assign w_tag          = r_byte[2:0];
  assign w_wellFormed   = byte_well_formed(r_byte);
  assign w_tagMatch     = (w_tag == r_exp);
  assign w_frameTimeout = (r_state == S_WAIT) && (r_exp != 3'd0) && (r_frameTimer == FRAME_LAST);

  // Pop is gated by reset so a FIFO with data never loses a byte while we are held in reset.
  assign rd_uart = (r_state == S_WAIT) && !rx_empty && !rst;

  // Byte FSM, frame parser, shadow registers and the atomic copy to the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_WAIT;
      r_byte       <= 8'h00;
      r_exp        <= UART_TAG_HDR;
      r_shadow     <= '0;
      r_remote     <= '0;
      r_publish    <= 1'b0;
      r_frameValid <= 1'b0;
      r_errCount   <= 8'h00;
    end else begin
      r_publish    <= 1'b0;
      r_frameValid <= 1'b0;

      if (r_publish) begin
        r_frameValid    <= 1'b1;
        r_remote.player <= r_shadow.player;
        if (player_active(r_shadow.player)) begin
          r_remote.x         <= r_shadow.x;
          r_remote.y         <= r_shadow.y;
          r_remote.collision <= r_shadow.collision;
        end
      end

      case (r_state)
        S_WAIT: begin
          if (!rx_empty) begin
            r_byte  <= r_data;
            r_state <= S_PARSE;
          end
        end
        S_PARSE: begin
          r_state <= S_WAIT;
          if (w_wellFormed && (w_tagMatch || w_tag == UART_TAG_HDR)) begin
            case (w_tag)
              UART_TAG_HDR:  r_shadow.player    <= r_byte[4:3];
              UART_TAG_XLO:  r_shadow.x[3:0]    <= r_byte[6:3];
              UART_TAG_XHI:  r_shadow.x[7:4]    <= r_byte[6:3];
              UART_TAG_YHI:  r_shadow.y[7:4]    <= r_byte[6:3];
              UART_TAG_YLO:  r_shadow.y[3:0]    <= r_byte[6:3];
              UART_TAG_COLL: r_shadow.collision <= r_byte[3];
              default: ;
            endcase
            // A header arriving mid-frame aborts the old frame but starts a new one.
            if (!w_tagMatch) begin
              r_errCount <= sat_inc8(r_errCount);
              r_exp      <= 3'd1;
            end else if (w_tag == UART_TAG_COLL) begin
              r_exp     <= UART_TAG_HDR;
              r_publish <= 1'b1;
            end else begin
              r_exp <= r_exp + 3'd1;
            end
          end else if (r_exp == UART_TAG_HDR && w_tag != UART_TAG_HDR) begin
            r_exp <= UART_TAG_HDR;
          end else begin
            r_exp      <= UART_TAG_HDR;
            r_errCount <= sat_inc8(r_errCount);
          end
        end
        default: r_state <= S_WAIT;
      endcase

      if (w_frameTimeout) begin
        r_exp      <= UART_TAG_HDR;
        r_errCount <= sat_inc8(r_errCount);
      end
    end
  end

  // Inter-byte timer only runs while a frame is open and restarts whenever a byte is handled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frameTimer <= '0;
    end else if (r_state == S_PARSE || r_exp == UART_TAG_HDR || w_frameTimeout) begin
      r_frameTimer <= '0;
    end else begin
      r_frameTimer <= r_frameTimer + 1'b1;
    end
  end

  // Link watchdog: a fresh frame always wins over a simultaneous expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_linkTimer <= '0;
      r_linkUp    <= 1'b0;
    end else if (r_publish) begin
      r_linkTimer <= '0;
      r_linkUp    <= 1'b1;
    end else begin
      if (r_linkTimer != LINK_MAX) begin
        r_linkTimer <= r_linkTimer + 1'b1;
      end
      if (r_linkTimer == LINK_MAX) begin
        r_linkUp <= 1'b0;
      end
    end
  end

  assign remote_player    = r_remote.player;
  assign remote_x         = r_remote.x;
  assign remote_y         = r_remote.y;
  assign remote_collision = r_remote.collision;
  assign frame_valid      = r_frameValid;
  assign link_up          = r_linkUp;
  assign err_count        = r_errCount;

endmodule

// File: tb/tb_uart_decoder.sv
// Directed bench for uart_decoder: a queue models the first-word-fall-through RX FIFO.
module tb_uart_decoder;

  localparam int FT = 50;
  localparam int LT = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart;
  logic [1:0] remote_player;
  logic [7:0] remote_x;
  logic [7:0] remote_y;
  logic       remote_collision;
  logic       frame_valid;
  logic       link_up;
  logic [7:0] err_count;

  logic [7:0] fifoQ[$];
  logic [7:0] pushLog[$];
  logic [7:0] popLog[$];
  logic       popReq = 1'b0;
  logic       gate = 1'b0;
  logic       toggleMode = 1'b0;
  logic       rdPrev = 1'b0;
  logic       fvPrev = 1'b0;
  int         rdBackToBack = 0;
  int         fvCount = 0;
  int         fvLong = 0;
  int         nApplied = 0;
  int         nMis = 0;
  int         fvBase;

  uart_decoder #(.FRAME_TIMEOUT(FT), .LINK_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .remote_player(remote_player), .remote_x(remote_x), .remote_y(remote_y),
    .remote_collision(remote_collision), .frame_valid(frame_valid), .link_up(link_up),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // FIFO model: pops the byte that was strobed during the previous cycle, then refreshes the head.
  always @(negedge clk) begin
    if (popReq && fifoQ.size() > 0) begin
      popLog.push_back(fifoQ[0]);
      void'(fifoQ.pop_front());
    end
    popReq = 1'b0;
    if (toggleMode) gate = ~gate;
    else gate = 1'b0;
    rx_empty = (fifoQ.size() == 0) || gate;
    r_data   = (fifoQ.size() != 0) ? fifoQ[0] : 8'h00;
    if (frame_valid) fvCount++;
    if (frame_valid && fvPrev) fvLong++;
    fvPrev = frame_valid;
  end

  // Sample the pop strobe late in the cycle, once rx_empty has settled.
  always @(negedge clk) begin
    #4;
    popReq = rd_uart;
    if (rd_uart && rdPrev) rdBackToBack++;
    rdPrev = rd_uart;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic pushByte(input logic [7:0] b);
    fifoQ.push_back(b);
    pushLog.push_back(b);
  endtask

  task automatic pushValidFrame(input logic [1:0] p, input logic [7:0] x, input logic [7:0] y,
                                input logic c);
    pushByte({1'b0, 2'b00, p, 3'd0});
    pushByte({1'b0, x[3:0], 3'd1});
    pushByte({1'b0, x[7:4], 3'd2});
    pushByte({1'b0, y[7:4], 3'd3});
    pushByte({1'b0, y[3:0], 3'd4});
    pushByte({1'b0, 3'b000, c, 3'd5});
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (fifoQ.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    nApplied++;
    if (fifoQ.size() != 0) begin
      $display("[TB] FAIL drain: %0d bytes left, required 0", fifoQ.size());
      nMis++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    pushByte(8'h01);
    repeat (2) @(negedge clk);
    nApplied++; if (rd_uart !== 1'b0) begin $display("[TB] FAIL reset_pop: got %b want 0", rd_uart); nMis++; end
    nApplied++; if (remote_player !== 2'b00) begin $display("[TB] FAIL reset_player: got %h want 0", remote_player); nMis++; end
    nApplied++; if (remote_x !== 8'h00) begin $display("[TB] FAIL reset_x: got %h want 00", remote_x); nMis++; end
    nApplied++; if (remote_y !== 8'h00) begin $display("[TB] FAIL reset_y: got %h want 00", remote_y); nMis++; end
    nApplied++; if (frame_valid !== 1'b0) begin $display("[TB] FAIL reset_fv: got %b want 0", frame_valid); nMis++; end
    nApplied++; if (link_up !== 1'b0) begin $display("[TB] FAIL reset_link: got %b want 0", link_up); nMis++; end
    rst = 1'b0;
    waitIdle();
    nApplied++; if (err_count !== 8'd0) begin $display("[TB] FAIL stray_no_err: got %0d want 0", err_count); nMis++; end
    nApplied++; if (fvCount !== 0) begin $display("[TB] FAIL stray_no_fv: got %0d want 0", fvCount); nMis++; end
  endtask

  task automatic test_valid_frame();
    pushByte(8'h08); pushByte(8'h29); pushByte(8'h4A);
    pushByte(8'h7B); pushByte(8'h34); pushByte(8'h0D);
    waitIdle();
    nApplied++; if (remote_player !== 2'b01) begin $display("[TB] FAIL t1_player: got %h want 1", remote_player); nMis++; end
    nApplied++; if (remote_x !== 8'h95) begin $display("[TB] FAIL t1_x: got %h want 95", remote_x); nMis++; end
    nApplied++; if (remote_y !== 8'hF6) begin $display("[TB] FAIL t1_y: got %h want F6", remote_y); nMis++; end
    nApplied++; if (remote_collision !== 1'b1) begin $display("[TB] FAIL t1_coll: got %b want 1", remote_collision); nMis++; end
    nApplied++; if (fvCount !== 1) begin $display("[TB] FAIL t1_fv_count: got %0d want 1", fvCount); nMis++; end
    nApplied++; if (err_count !== 8'd0) begin $display("[TB] FAIL t1_err: got %0d want 0", err_count); nMis++; end
    nApplied++; if (link_up !== 1'b1) begin $display("[TB] FAIL t1_link: got %b want 1", link_up); nMis++; end
  endtask

  task automatic test_null_header();
    fvBase = fvCount;
    for (int i = 0; i < 6; i++) pushByte(8'(i));
    waitIdle();
    nApplied++; if (remote_player !== 2'b00) begin $display("[TB] FAIL t2_player: got %h want 0", remote_player); nMis++; end
    nApplied++; if (remote_x !== 8'h95) begin $display("[TB] FAIL t2_x_held: got %h want 95", remote_x); nMis++; end
    nApplied++; if (remote_y !== 8'hF6) begin $display("[TB] FAIL t2_y_held: got %h want F6", remote_y); nMis++; end
    nApplied++; if (remote_collision !== 1'b1) begin $display("[TB] FAIL t2_coll_held: got %b want 1", remote_collision); nMis++; end
    nApplied++; if (fvCount - fvBase !== 1) begin $display("[TB] FAIL t2_fv: got %0d want 1", fvCount - fvBase); nMis++; end
  endtask

  task automatic test_early_tag();
    fvBase = fvCount;
    pushByte(8'h08); pushByte(8'h29); pushByte(8'h0B);
    pushValidFrame(2'b11, 8'h3C, 8'hA7, 1'b0);
    waitIdle();
    nApplied++; if (err_count !== 8'd1) begin $display("[TB] FAIL t3_err: got %0d want 1", err_count); nMis++; end
    nApplied++; if (remote_player !== 2'b11) begin $display("[TB] FAIL t3_player: got %h want 3", remote_player); nMis++; end
    nApplied++; if (remote_x !== 8'h3C) begin $display("[TB] FAIL t3_x: got %h want 3C", remote_x); nMis++; end
    nApplied++; if (remote_y !== 8'hA7) begin $display("[TB] FAIL t3_y: got %h want A7", remote_y); nMis++; end
    nApplied++; if (remote_collision !== 1'b0) begin $display("[TB] FAIL t3_coll: got %b want 0", remote_collision); nMis++; end
    nApplied++; if (fvCount - fvBase !== 1) begin $display("[TB] FAIL t3_fv: got %0d want 1", fvCount - fvBase); nMis++; end
  endtask

  task automatic test_header_restart();
    fvBase = fvCount;
    pushByte(8'h08); pushByte(8'h29);
    pushValidFrame(2'b01, 8'hAB, 8'hCD, 1'b0);
    waitIdle();
    nApplied++; if (err_count !== 8'd2) begin $display("[TB] FAIL restart_err: got %0d want 2", err_count); nMis++; end
    nApplied++; if (remote_x !== 8'hAB) begin $display("[TB] FAIL restart_x: got %h want AB", remote_x); nMis++; end
    nApplied++; if (remote_y !== 8'hCD) begin $display("[TB] FAIL restart_y: got %h want CD", remote_y); nMis++; end
    nApplied++; if (fvCount - fvBase !== 1) begin $display("[TB] FAIL restart_fv: got %0d want 1", fvCount - fvBase); nMis++; end
  endtask

  task automatic test_frame_timeout();
    fvBase = fvCount;
    pushByte(8'h08); pushByte(8'h29);
    waitIdle();
    nApplied++; if (err_count !== 8'd2) begin $display("[TB] FAIL t4_err_before: got %0d want 2", err_count); nMis++; end
    repeat (FT + 10) @(negedge clk);
    nApplied++; if (err_count !== 8'd3) begin $display("[TB] FAIL t4_err_timeout: got %0d want 3", err_count); nMis++; end
    pushValidFrame(2'b01, 8'h12, 8'h34, 1'b1);
    waitIdle();
    nApplied++; if (err_count !== 8'd3) begin $display("[TB] FAIL t4_err_after: got %0d want 3", err_count); nMis++; end
    nApplied++; if (remote_x !== 8'h12) begin $display("[TB] FAIL t4_x: got %h want 12", remote_x); nMis++; end
    nApplied++; if (remote_y !== 8'h34) begin $display("[TB] FAIL t4_y: got %h want 34", remote_y); nMis++; end
    nApplied++; if (fvCount - fvBase !== 1) begin $display("[TB] FAIL t4_fv: got %0d want 1", fvCount - fvBase); nMis++; end
  endtask

  task automatic test_back_to_back();
    int orderErr;
    fvBase = fvCount;
    pushLog.delete();
    popLog.delete();
    rdBackToBack = 0;
    toggleMode = 1'b1;
    pushByte(8'h08); pushByte(8'h29); pushByte(8'hA9);
    pushValidFrame(2'b11, 8'hFE, 8'h01, 1'b1);
    waitIdle();
    toggleMode = 1'b0;
    orderErr = 0;
    for (int i = 0; i < pushLog.size() && i < popLog.size(); i++)
      if (popLog[i] !== pushLog[i]) orderErr++;
    nApplied++; if (err_count !== 8'd4) begin $display("[TB] FAIL t5_err: got %0d want 4", err_count); nMis++; end
    nApplied++; if (rdBackToBack !== 0) begin $display("[TB] FAIL t5_rd_b2b: got %0d want 0", rdBackToBack); nMis++; end
    nApplied++; if (popLog.size() !== 9) begin $display("[TB] FAIL t5_pop_count: got %0d want 9", popLog.size()); nMis++; end
    nApplied++; if (orderErr !== 0) begin $display("[TB] FAIL t5_pop_order: got %0d bad want 0", orderErr); nMis++; end
    nApplied++; if (remote_x !== 8'hFE) begin $display("[TB] FAIL t5_x: got %h want FE", remote_x); nMis++; end
    nApplied++; if (remote_y !== 8'h01) begin $display("[TB] FAIL t5_y: got %h want 01", remote_y); nMis++; end
    nApplied++; if (fvCount - fvBase !== 1) begin $display("[TB] FAIL t5_fv: got %0d want 1", fvCount - fvBase); nMis++; end
    nApplied++; if (fvLong !== 0) begin $display("[TB] FAIL fv_width: got %0d long pulses want 0", fvLong); nMis++; end
  endtask

  task automatic test_link_timeout();
    nApplied++; if (link_up !== 1'b1) begin $display("[TB] FAIL t6_link_before: got %b want 1", link_up); nMis++; end
    repeat (LT + 20) @(negedge clk);
    nApplied++; if (link_up !== 1'b0) begin $display("[TB] FAIL t6_link_drop: got %b want 0", link_up); nMis++; end
  endtask

  task automatic test_reset_midframe();
    fvBase = fvCount;
    pushByte(8'h08); pushByte(8'h29); pushByte(8'h4A);
    waitIdle();
    #2 rst = 1'b1;
    #1;
    nApplied++; if (remote_player !== 2'b00) begin $display("[TB] FAIL rst_player: got %h want 0", remote_player); nMis++; end
    nApplied++; if (remote_x !== 8'h00) begin $display("[TB] FAIL rst_x: got %h want 00", remote_x); nMis++; end
    nApplied++; if (remote_collision !== 1'b0) begin $display("[TB] FAIL rst_coll: got %b want 0", remote_collision); nMis++; end
    nApplied++; if (err_count !== 8'd0) begin $display("[TB] FAIL rst_err: got %0d want 0", err_count); nMis++; end
    @(negedge clk);
    rst = 1'b0;
    pushByte(8'h7B); pushByte(8'h34); pushByte(8'h0D);
    waitIdle();
    nApplied++; if (fvCount - fvBase !== 0) begin $display("[TB] FAIL rst_tail_fv: got %0d want 0", fvCount - fvBase); nMis++; end
    nApplied++; if (err_count !== 8'd0) begin $display("[TB] FAIL rst_tail_err: got %0d want 0", err_count); nMis++; end
    pushValidFrame(2'b01, 8'h5A, 8'hA5, 1'b1);
    waitIdle();
    nApplied++; if (remote_x !== 8'h5A) begin $display("[TB] FAIL rst_new_x: got %h want 5A", remote_x); nMis++; end
    nApplied++; if (remote_y !== 8'hA5) begin $display("[TB] FAIL rst_new_y: got %h want A5", remote_y); nMis++; end
    nApplied++; if (link_up !== 1'b1) begin $display("[TB] FAIL rst_new_link: got %b want 1", link_up); nMis++; end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_null_header();
    test_early_tag();
    test_header_restart();
    test_frame_timeout();
    test_back_to_back();
    test_link_timeout();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMis);
    $finish;
  end

endmodule
